// File: rtl/lsf_mult_arbiter_if.sv
// Request/result bundle between the LSF r-offset calculators and the shared multiplier arbiter.
// master = requester/consumer side, slave = arbiter side.
interface lsf_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int A_W   = 18,
  parameter int B_W   = 15,
  parameter int P_W   = 33,
  parameter int TAG_W = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*A_W-1:0]   req_a;
  logic [N_REQ*B_W-1:0]   req_b;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic [N_REQ-1:0]       res_valid;
  logic [P_W-1:0]         res_p;
  logic [TAG_W-1:0]       res_tag;

  modport master (
    output req_valid, req_a, req_b, req_tag,
    input  req_ready, res_valid, res_p, res_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag,
    output req_ready, res_valid, res_p, res_tag
  );
endinterface

// File: rtl/lsf_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier, with flush/drain and tagged results.
// Optional per-requester saturating grant counters: define LSF_MULT_ARB_CNT_EN.
module lsf_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int A_W     = 18,
  parameter int B_W     = 15,
  parameter int P_W     = 33,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  lsf_mult_arbiter_if.slave   bus,
  input  logic                flush,
  output logic                flush_done,
  output logic                busy,
  output logic [N_REQ*16-1:0] grant_cnt
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int NST   = MUL_LAT - 1;
  localparam int IF_W  = $clog2(MUL_LAT + 1);

  generate
    if (P_W != A_W + B_W) begin : gPwCheck
      $error("lsf_mult_arbiter: P_W must equal A_W+B_W");
    end
    if (MUL_LAT < 2) begin : gLatCheck
      $error("lsf_mult_arbiter: MUL_LAT must be at least 2");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : gReqCheck
      $error("lsf_mult_arbiter: N_REQ must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;
  logic [IF_W-1:0]   inFlight_q, inFlight_d;
  logic              flush_q;

  logic [N_REQ-1:0]  grant;
  logic              grantEn, flushRise, accept, resDone;
  logic [A_W-1:0]    aSel;
  logic [B_W-1:0]    bSel;
  logic [TAG_W-1:0]  tagSel;
  int                idx;

  logic [N_REQ-1:0]         s1Own_q;
  logic signed [A_W-1:0]    s1A_q;
  logic signed [B_W-1:0]    s1B_q;
  logic [TAG_W-1:0]         s1Tag_q;
  logic signed [P_W-1:0]    aExt, bExt, prodFull;

  logic [N_REQ-1:0]  own_q  [NST];
  logic [P_W-1:0]    prod_q [NST];
  logic [TAG_W-1:0]  tag_q  [NST];

  assign flushRise = flush & ~flush_q;
  // A level-high flush blocks grants, which also covers the grant coincident with its rising edge.
  assign grantEn   = !ap_rst && (state_q != DRAIN) && !flush;

  always_comb begin
    grant   = '0;
    rrPtr_d = rrPtr_q;
    aSel    = '0;
    bSel    = '0;
    tagSel  = '0;
    idx     = 0;
    if (grantEn) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rrPtr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (grant == '0 && bus.req_valid[idx]) begin
          grant[idx] = 1'b1;
          rrPtr_d    = (idx + 1 == N_REQ) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        aSel   = bus.req_a[i*A_W +: A_W];
        bSel   = bus.req_b[i*B_W +: B_W];
        tagSel = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign accept        = |grant;
  assign resDone       = |own_q[NST-1];
  assign bus.req_ready = grant;
  assign bus.res_valid = own_q[NST-1];
  assign bus.res_p     = prod_q[NST-1];
  assign bus.res_tag   = tag_q[NST-1];

  assign aExt     = P_W'(s1A_q);
  assign bExt     = P_W'(s1B_q);
  assign prodFull = aExt * bExt;

  assign inFlight_d = inFlight_q + IF_W'(accept) - IF_W'(resDone);

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (flushRise)   state_d = DRAIN;
        else if (accept) state_d = RUN;
      end
      RUN: begin
        if (flushRise)                             state_d = DRAIN;
        else if (inFlight_q == '0 && !accept)      state_d = IDLE;
      end
      DRAIN: begin
        if (inFlight_q == '0) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) || (inFlight_q != '0);

  // Payload registers only load behind a valid owner so res_p/res_tag hold between pulses.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      inFlight_q <= '0;
      flush_q    <= 1'b0;
      s1Own_q    <= '0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Tag_q    <= '0;
      for (int s = 0; s < NST; s++) begin
        own_q[s]  <= '0;
        prod_q[s] <= '0;
        tag_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      inFlight_q <= inFlight_d;
      flush_q    <= flush;
      s1Own_q    <= grant;
      if (accept) begin
        s1A_q   <= aSel;
        s1B_q   <= bSel;
        s1Tag_q <= tagSel;
      end
      own_q[0] <= s1Own_q;
      if (|s1Own_q) begin
        prod_q[0] <= prodFull;
        tag_q[0]  <= s1Tag_q;
      end
      for (int s = 1; s < NST; s++) begin
        own_q[s] <= own_q[s-1];
        if (|own_q[s-1]) begin
          prod_q[s] <= prod_q[s-1];
          tag_q[s]  <= tag_q[s-1];
        end
      end
    end
  end

`ifdef LSF_MULT_ARB_CNT_EN
  logic [15:0] grantCnt_q [N_REQ];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < N_REQ; i++) grantCnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (flush_done)                                grantCnt_q[i] <= '0;
        else if (grant[i] && grantCnt_q[i] != 16'hFFFF) grantCnt_q[i] <= grantCnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*16 +: 16] = grantCnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
